e1_tx_framer: RTL

E1 transmit framer: counterpart of the RX deframer and buffer-descriptor logic. It reads timeslot bytes from the TX buffer under buffer-descriptor control and generates TS0 (FAS/NFAS, CRC-4 multiframe, E-bits). It serializes the G.704 frame MSB-first, one bit per line-rate tick. Its output feeds the HDB3 encoder / TX PHY, or an external LIU.

---
 rtl/e1_tx_framer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/e1_tx_framer.sv
// E1 transmit framer: builds TS0 (FAS/NFAS, CRC-4 multiframe, E-bits), fetches TS1..31 from the TX buffer per descriptor.
// Line bit registered 1 clk after i_tick; no backpressure, a missing descriptor sends 0xFF and pulses o_bd_miss.
module e1_tx_framer #(
  parameter int MFW = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_tick,
  input  logic [7:0]     i_buf_data,
  output logic [4:0]     o_buf_ts,
  output logic [3:0]     o_buf_frame,
  output logic [MFW-1:0] o_buf_mf,
  output logic           o_buf_re,
  input  logic [MFW-1:0] i_bd_mf,
  input  logic [1:0]     i_bd_crc_e,
  input  logic           i_bd_valid,
  output logic           o_bd_done,
  output logic           o_bd_miss,
  output logic           o_out_bit,
  output logic           o_out_valid
);

  logic [2:0]     r_bit;
  logic [4:0]     r_ts;
  logic [3:0]     r_frame;
  logic [7:0]     r_shift;
  logic [7:0]     r_hold;
  logic           r_re_d;
  logic           r_mf_valid;
  logic [MFW-1:0] r_mf;
  logic [1:0]     r_ebits;
  logic [3:0]     r_crc;
  logic [3:0]     r_cbits;
  logic [4:0]     r_buf_ts;
  logic [3:0]     r_buf_frame;
  logic           r_buf_re;
  logic           r_bd_done;
  logic           r_bd_miss;
  logic           r_out_bit;
  logic           r_out_valid;

  logic       w_slot_start;
  logic       w_mf_start;
  logic       w_mf_end;
  logic       w_smf_end;
  logic       w_mf_valid;
  logic       w_si;
  logic [1:0] w_cidx;
  logic       w_cbit;
  logic [7:0] w_ts0;
  logic [7:0] w_byte;
  logic       w_tx_bit;
  logic       w_crc_in;
  logic       w_fb;
  logic [3:0] w_crc_next;

  assign w_slot_start = (r_bit == 3'd0);
  assign w_mf_start   = (r_frame == 4'd0) && (r_ts == 5'd0) && w_slot_start;
  assign w_mf_end     = (r_frame == 4'd15) && (r_ts == 5'd31) && (r_bit == 3'd7);
  assign w_smf_end    = (r_frame[2:0] == 3'd7) && (r_ts == 5'd31) && (r_bit == 3'd7);
  // The descriptor is sampled on the start tick itself so the TS1 prefetch can go out on that tick.
  assign w_mf_valid   = w_mf_start ? i_bd_valid : r_mf_valid;

  always_comb begin
    w_si = 1'b0;
    case (r_frame)
      4'd5, 4'd9, 4'd11: w_si = 1'b1;
      4'd13:             w_si = r_ebits[0];
      4'd15:             w_si = r_ebits[1];
      default:           w_si = 1'b0;
    endcase
  end

  // Frame pairs 0/2/4/6 within each SMF carry C1..C4, C1 being the remainder MSB.
  assign w_cidx = ~r_frame[2:1];
  assign w_cbit = r_cbits[w_cidx];
  assign w_ts0  = r_frame[0] ? {w_si, 1'b1, 1'b0, 5'b11111} : {w_cbit, 7'b0011011};
  assign w_byte = (r_ts == 5'd0) ? w_ts0 : (r_mf_valid ? r_hold : 8'hFF);

  assign w_tx_bit   = w_slot_start ? w_byte[7] : r_shift[7];
  assign w_crc_in   = ((r_ts == 5'd0) && w_slot_start && !r_frame[0]) ? 1'b0 : w_tx_bit;
  assign w_fb       = w_crc_in ^ r_crc[3];
  assign w_crc_next = {r_crc[2], r_crc[1], r_crc[0] ^ w_fb, w_fb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit       <= '0;
      r_ts        <= '0;
      r_frame     <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_re_d      <= 1'b0;
      r_mf_valid  <= 1'b0;
      r_mf        <= '0;
      r_ebits     <= 2'b11;
      r_crc       <= '0;
      r_cbits     <= '0;
      r_buf_ts    <= '0;
      r_buf_frame <= '0;
      r_buf_re    <= 1'b0;
      r_bd_done   <= 1'b0;
      r_bd_miss   <= 1'b0;
      r_out_bit   <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= i_tick;
      r_buf_re    <= 1'b0;
      r_bd_done   <= 1'b0;
      r_bd_miss   <= 1'b0;
      r_re_d      <= r_buf_re;
      if (r_re_d) r_hold <= i_buf_data;

      if (i_tick) begin
        r_out_bit <= w_tx_bit;
        r_shift   <= w_slot_start ? {w_byte[6:0], 1'b0} : {r_shift[6:0], 1'b0};
        r_bit     <= r_bit + 3'd1;
        if (r_bit == 3'd7) begin
          r_ts <= r_ts + 5'd1;
          if (r_ts == 5'd31) r_frame <= r_frame + 4'd1;
        end

        if (w_smf_end) begin
          r_cbits <= w_crc_next;
          r_crc   <= '0;
        end else begin
          r_crc <= w_crc_next;
        end

        if (w_mf_start) begin
          r_mf_valid <= i_bd_valid;
          r_mf       <= i_bd_mf;
          r_ebits    <= ~i_bd_crc_e;
          r_bd_miss  <= !i_bd_valid;
        end
        if (w_mf_end) r_bd_done <= r_mf_valid;

        // TS0 is generated locally, so the slot-31 tick never prefetches.
        if (w_slot_start && w_mf_valid && (r_ts != 5'd31)) begin
          r_buf_re    <= 1'b1;
          r_buf_ts    <= r_ts + 5'd1;
          r_buf_frame <= r_frame;
        end
      end
    end
  end

  assign o_buf_ts    = r_buf_ts;
  assign o_buf_frame = r_buf_frame;
  assign o_buf_mf    = r_mf;
  assign o_buf_re    = r_buf_re;
  assign o_bd_done   = r_bd_done;
  assign o_bd_miss   = r_bd_miss;
  assign o_out_bit   = r_out_bit;
  assign o_out_valid = r_out_valid;

endmodule
